// File: rtl/dmux_8way_pkg.sv
// hack_pkg: shared constants for the Hack basic-gates layer.
//   SEL_A..SEL_H : select codes that route the demux input to outputs a..h.
//   NUM_OUT      : number of demux outputs.
package hack_pkg;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;
  localparam logic [2:0] SEL_F = 3'd5;
  localparam logic [2:0] SEL_G = 3'd6;
  localparam logic [2:0] SEL_H = 3'd7;

  localparam int NUM_OUT = 8;

endpackage

// File: rtl/dmux_8way_if.sv
// dmux_8way_if: bundle of the demux data/select inputs and its eight outputs.
//   in       : WIDTH-bit data to route
//   sel      : 3-bit output select, sel[2] is the MSB
//   a..h     : WIDTH-bit outputs, selected by codes 0..7
// Modports:
//   master : drives in/sel, observes a..h (the user of the demux)
//   slave  : observes in/sel, drives a..h (the demux itself)
interface dmux_8way_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] in;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;

  modport master (
    output in, sel,
    input  a, b, c, d, e, f, g, h
  );

  modport slave (
    input  in, sel,
    output a, b, c, d, e, f, g, h
  );

endinterface

// File: rtl/dmux_8way_4way.sv
// dmux_4way: one-input, four-output demultiplexer.
//   in      : WIDTH-bit data to route
//   sel     : 2-bit select (00->a, 01->b, 10->c, 11->d)
//   a..d    : outputs; the selected one carries in, the rest are zero
// Purely combinational. Only fully specified select codes are decoded, so an
// unknown select never aliases onto a valid output.
module dmux_4way
  import hack_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    case (sel)
      SEL_A[1:0]: a = in;
      SEL_B[1:0]: b = in;
      SEL_C[1:0]: c = in;
      SEL_D[1:0]: d = in;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmux_8way.sv
// dmux_8way: one-input, eight-output demultiplexer for the Hack gate library.
//   clk     : clock, only used when REG_OUT=1
//   rst     : synchronous active-high reset, only used when REG_OUT=1
//   bus     : dmux_8way_if slave port (in, sel inputs; a..h outputs)
// Parameters:
//   WIDTH   : lane width of in and of each output
//   REG_OUT : 0 = combinational outputs, 1 = outputs registered on clk
// sel[2] splits in between the lower (a..d) and upper (e..h) half; each half
// is a dmux_4way steered by sel[1:0]. The half that is not selected sees a
// zero input, so at most one output is ever nonzero.
module dmux_8way
  import hack_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  dmux_8way_if.slave   bus
);

  logic [1:0][WIDTH-1:0]       half_in;
  logic [NUM_OUT-1:0][WIDTH-1:0] out_d;
  logic [NUM_OUT-1:0][WIDTH-1:0] out_final;

  // 1-to-2 split on sel[2], then a 4-way decode inside each half.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign half_in[gi] = (bus.sel[2] == 1'(gi)) ? bus.in : '0;

      dmux_4way #(
        .WIDTH (WIDTH)
      ) u_quad (
        .in  (half_in[gi]),
        .sel (bus.sel[1:0]),
        .a   (out_d[4*gi + 0]),
        .b   (out_d[4*gi + 1]),
        .c   (out_d[4*gi + 2]),
        .d   (out_d[4*gi + 3])
      );
    end
  endgenerate

  generate
    if (REG_OUT) begin : g_reg
      logic [NUM_OUT-1:0][WIDTH-1:0] out_q;

      // Reset wins over the load; the whole decoded vector is captured in
      // one edge, so the registered outputs stay one-hot-or-zero even when
      // sel moves between edges.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign out_final = out_q;
    end else begin : g_comb
      assign out_final = out_d;

      // clk and rst are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
    end
  endgenerate

  assign bus.a = out_final[SEL_A];
  assign bus.b = out_final[SEL_B];
  assign bus.c = out_final[SEL_C];
  assign bus.d = out_final[SEL_D];
  assign bus.e = out_final[SEL_E];
  assign bus.f = out_final[SEL_F];
  assign bus.g = out_final[SEL_G];
  assign bus.h = out_final[SEL_H];

endmodule

// File: tb/tb_dmux_8way.sv
// tb_dmux_8way: directed bench for dmux_8way.
// Three instances: 1-bit combinational, 16-bit combinational, 1-bit registered.
module tb_dmux_8way;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  dmux_8way_if #(.WIDTH(1))  if1  ();
  dmux_8way_if #(.WIDTH(16)) if16 ();
  dmux_8way_if #(.WIDTH(1))  ifr  ();

  dmux_8way #(.WIDTH(1), .REG_OUT(1'b0)) u_comb1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  dmux_8way #(.WIDTH(16), .REG_OUT(1'b0)) u_comb16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  dmux_8way #(.WIDTH(1), .REG_OUT(1'b1)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (ifr.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {h,g,f,e,d,c,b,a}.
  task automatic chk1(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {if1.h, if1.g, if1.f, if1.e, if1.d, if1.c, if1.b, if1.a};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("cmp %s in=%b sel=%0d hgfedcba=%b", tag, if1.in, if1.sel, obs);
  endtask

  task automatic chkr(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {ifr.h, ifr.g, ifr.f, ifr.e, ifr.d, ifr.c, ifr.b, ifr.a};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("cmp %s rst=%b in=%b sel=%0d hgfedcba=%b", tag, rst, ifr.in, ifr.sel, obs);
  endtask

  // Expected for the 16-bit instance: output number s carries v, all others 0.
  task automatic chk16(input string tag, input int s, input logic [15:0] v);
    logic [7:0][15:0] obs;
    logic [7:0][15:0] exp;
    obs = {if16.h, if16.g, if16.f, if16.e, if16.d, if16.c, if16.b, if16.a};
    exp = '0;
    exp[s] = v;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("cmp %s in=%h sel=%0d hgfedcba=%h", tag, if16.in, if16.sel, obs);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if1.in = 1'b0;  if1.sel = 3'd0;
    if16.in = '0;   if16.sel = 3'd0;
    // Loaded-looking inputs during reset: reset must still hold outputs at 0.
    ifr.in = 1'b1;  ifr.sel = 3'd3;

    // Registered: two reset edges, outputs zero.
    repeat (2) @(posedge clk);
    #1 chkr("reg_reset", 8'b0000_0000);

    // Combinational, in=1, sel stepped 0..7 at 10 ns.
    @(negedge clk);
    if1.in = 1'b1;
    if1.sel = 3'd0; #10 chk1("step_a", 8'b0000_0001);
    if1.sel = 3'd1; #10 chk1("step_b", 8'b0000_0010);
    if1.sel = 3'd2; #10 chk1("step_c", 8'b0000_0100);
    if1.sel = 3'd3; #10 chk1("step_d", 8'b0000_1000);
    if1.sel = 3'd4; #10 chk1("step_e", 8'b0001_0000);
    if1.sel = 3'd5; #10 chk1("step_f", 8'b0010_0000);
    if1.sel = 3'd6; #10 chk1("step_g", 8'b0100_0000);
    if1.sel = 3'd7; #10 chk1("step_h", 8'b1000_0000);

    // in=0: everything zero for sel=3 and then every code.
    if1.in = 1'b0;
    if1.sel = 3'd3; #10 chk1("zero_sel3", 8'b0000_0000);
    for (int s = 0; s < 8; s++) begin
      if1.sel = 3'(s);
      #10 chk1($sformatf("zero_sel%0d", s), 8'b0000_0000);
    end

    // Exhaustive 16 combinations against a one-hot reference.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] ref_v;
      if1.in  = k[3];
      if1.sel = k[2:0];
      ref_v   = k[3] ? (8'b0000_0001 << k[2:0]) : 8'b0000_0000;
      #10 chk1($sformatf("exh_in%0d_sel%0d", k[3], k[2:0]), ref_v);
    end

    // 16-bit lanes.
    if16.in = 16'hA5C3; if16.sel = 3'd5;
    #10 chk16("w16_a5c3_sel5", 5, 16'hA5C3);
    if16.in = 16'hFFFF;
    for (int s = 0; s < 8; s++) begin
      if16.sel = 3'(s);
      #10 chk16($sformatf("w16_ffff_sel%0d", s), s, 16'hFFFF);
    end

    // Registered: release reset with in=1, sel=6; g after exactly one edge.
    @(negedge clk);
    rst = 1'b0;
    ifr.in = 1'b1; ifr.sel = 3'd6;
    #2 chkr("reg_before_edge", 8'b0000_0000);
    @(posedge clk); #1 chkr("reg_first_load_g", 8'b0100_0000);

    @(negedge clk);
    ifr.sel = 3'd2;
    #2 chkr("reg_hold_g", 8'b0100_0000);
    @(posedge clk); #1 chkr("reg_load_c", 8'b0000_0100);

    // sel moving between edges: only the value at the edge is captured.
    @(negedge clk);
    ifr.sel = 3'd7;
    #2 ifr.sel = 3'd1;
    @(posedge clk); #1 chkr("reg_midcycle_sel_b", 8'b0000_0010);

    // Reset mid-stream clears at the next edge.
    @(negedge clk);
    rst = 1'b1; ifr.sel = 3'd4;
    @(posedge clk); #1 chkr("reg_mid_reset", 8'b0000_0000);

    // First edge after deassertion loads the presented decode.
    @(negedge clk);
    rst = 1'b0; ifr.sel = 3'd5;
    @(posedge clk); #1 chkr("reg_reload_f", 8'b0010_0000);

    @(negedge clk);
    ifr.in = 1'b0;
    @(posedge clk); #1 chkr("reg_in_zero", 8'b0000_0000);

    // Combinational build ignores clk and rst.
    @(negedge clk);
    if1.in = 1'b1; if1.sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      rst = ~rst;
      @(posedge clk); #1 chk1($sformatf("comb_ctrl_pos%0d", i), 8'b0001_0000);
      @(negedge clk); #1 chk1($sformatf("comb_ctrl_neg%0d", i), 8'b0001_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
